// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : fetch_unit_pkg
//  Description: Shared types for the instruction-fetch stage: instruction bus
//               request/response, fetch-to-decode payload, FSM states and
//               next-PC select codes.
//  Revision   : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam int ILEN           = 32;
  localparam u64 PCINIT_DEFAULT = 64'h0000_0000_8000_0000;

  // Instruction bus request: held stable from issue until data_ok
  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  // Instruction bus response
  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  // Payload handed to decode
  typedef struct packed {
    u64              pc;
    logic [ILEN-1:0] raw_instr;
    logic            valid;
  } fetch_data_t;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  // Next-PC source selected by the fetch FSM
  typedef enum logic [1:0] {
    PC_KEEP  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_SAVED = 2'd3
  } pc_sel_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module     : fetch_unit_pc_gen
//  Description: Owns the fetch PC and the saved redirect target. The next PC
//               is chosen from {hold, pc+4, live redirect, saved target}.
//  Revision   : 1.0 - initial release
// ============================================================================
module fetch_unit_pc_gen
  import fetch_unit_pkg::*;
#(
  parameter u64 PCINIT = PCINIT_DEFAULT
) (
  input  logic    clk,
  input  logic    reset,
  input  pc_sel_t i_sel,
  input  logic    i_save_tgt,
  input  u64      i_redirect_pc,
  output u64      o_pc
);

  u64 r_pc;
  u64 r_target;

  // PC and saved-target registers; +4 wraps naturally at 64 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= PCINIT;
      r_target <= '0;
    end else begin
      case (i_sel)
        PC_INC:   r_pc <= r_pc + 64'd4;
        PC_REDIR: r_pc <= i_redirect_pc;
        PC_SAVED: r_pc <= r_target;
        default:  r_pc <= r_pc;
      endcase
      // Latest redirect seen while a stale request drains wins
      if (i_save_tgt) begin
        r_target <= i_redirect_pc;
      end
    end
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module     : fetch_unit
//  Description: Instruction-fetch stage. Issues requests on the instruction
//               bus, registers returned instructions for decode, holds them
//               across decode stalls and drops responses made stale by a
//               redirect.
//  Revision   : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter u64 PCINIT = PCINIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  u64          redirect_pc,
  output fetch_data_t dataF,
  output logic        busy
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  fetch_data_t  r_data;
  fetch_data_t  w_data_nxt;
  logic         r_active;
  logic         w_issue;
  pc_sel_t      w_pc_sel;
  logic         w_save_tgt;
  u64           w_pc;
  logic         w_unused_addr_ok;

  // Address acceptance is implied by data_ok; the handshake bit is not needed
  assign w_unused_addr_ok = iresp.addr_ok;

  // r_active keeps the bus idle for the first cycle after reset, so a stale
  // data_ok left over from before reset can never be mistaken for a response.
  assign w_issue = r_active && (r_state != HOLD);

  fetch_unit_pc_gen #(
    .PCINIT(PCINIT)
  ) u_pc_gen (
    .clk          (clk),
    .reset        (reset),
    .i_sel        (w_pc_sel),
    .i_save_tgt   (w_save_tgt),
    .i_redirect_pc(redirect_pc),
    .o_pc         (w_pc)
  );

  // Next-state, next-PC and next-output decision; redirect beats data_ok and stall
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_sel         = PC_KEEP;
    w_save_tgt       = 1'b0;
    w_data_nxt       = r_data;
    w_data_nxt.valid = 1'b0;
    case (r_state)
      REQ, WAIT: begin
        if (!w_issue) begin
          if (redirect_valid) begin
            w_pc_sel = PC_REDIR;
          end
        end else if (redirect_valid) begin
          if (iresp.data_ok) begin
            w_pc_sel    = PC_REDIR;
            w_state_nxt = REQ;
          end else begin
            w_save_tgt  = 1'b1;
            w_state_nxt = DROP;
          end
        end else if (iresp.data_ok) begin
          w_data_nxt.pc        = w_pc;
          w_data_nxt.raw_instr = iresp.data;
          w_data_nxt.valid     = 1'b1;
          if (stallF) begin
            w_state_nxt = HOLD;
          end else begin
            w_pc_sel    = PC_INC;
            w_state_nxt = REQ;
          end
        end else begin
          w_state_nxt = WAIT;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_pc_sel    = PC_REDIR;
          w_state_nxt = REQ;
        end else if (stallF) begin
          w_data_nxt.valid = 1'b1;
        end else begin
          w_pc_sel    = PC_INC;
          w_state_nxt = REQ;
        end
      end
      DROP: begin
        if (iresp.data_ok) begin
          w_pc_sel    = redirect_valid ? PC_REDIR : PC_SAVED;
          w_state_nxt = REQ;
        end else if (redirect_valid) begin
          w_save_tgt = 1'b1;
        end
      end
      default: w_state_nxt = REQ;
    endcase
  end

  // FSM state, bus-enable flag and registered decode payload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= REQ;
      r_active <= 1'b0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= 1'b1;
      r_data   <= w_data_nxt;
    end
  end

  // Bus request and status; a redirect squashes the presented instruction at once
  always_comb begin
    ireq.valid  = w_issue;
    ireq.addr   = w_pc;
    busy        = w_issue;
    dataF       = r_data;
    dataF.valid = r_data.valid & ~redirect_valid;
  end

endmodule
`default_nettype wire
